mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single byte-addressable data memory between the instruction-fetch (I) and load/store (D) ports.
//  Arbitrates requests with D priority and a starvation guard for I.
//  Drives address, byte enables, write data and write strobe to the memory; captures, aligns and sign/zero-extends read data.
//  Also sequences a memory dump request when the memory is otherwise idle.
// PARAMETERS
//  STARVE_LIMIT  4  consecutive arbitrations I may lose to D before I is forced to win (1..15)
// PORTS
//  clk            in   1   clock; all state updates on posedge
//  rst            in   1   reset, synchronous, active-high
//  i_req          in   1   I read request; held until i_gnt seen
//  i_addr         in   32  I word address
//  i_gnt          out  1   one-cycle pulse: I request accepted
//  i_rvalid       out  1   one-cycle pulse: i_rdata valid
//  i_rdata        out  32  fetched word
//  d_req          in   1   D request; held until d_gnt seen
//  d_wr           in   1   1=store, 0=load
//  d_size         in   2   00 byte, 01 half, 10 word, 11 illegal
//  d_signed       in   1   load sign-extends when 1
//  d_addr         in   32  byte address (unaligned permitted)
//  d_wdata        in   32  store data, right-justified
//  d_gnt          out  1   one-cycle pulse: D request accepted
//  d_rvalid       out  1   one-cycle pulse: load data / store ack
//  d_rdata        out  32  formatted load data (0 for stores)
//  d_err          out  1   valid with d_rvalid; 1 = illegal size
//  dump_req       in   1   level; request memory dump
//  dump_done      out  1   one-cycle pulse after dump strobe
//  mem_addr       out  32  to memory addr
//  mem_wdata      out  32  to memory data_in
//  mem_byte_en    out  4   to memory byte_enable
//  mem_wr         out  1   to memory wr
//  mem_dump       out  1   to memory createdump
//  mem_rdata      in   32  from memory data_out (combinational read)
// BEHAVIOUR
//  - States: IDLE, ACC_I, ACC_D, DUMP. Each non-IDLE state lasts exactly 1 cycle, then returns to IDLE.
//    Maximum throughput: one access per 2 cycles.
//  - IDLE arbitration (at posedge), in priority order:
//    - d_req and (starve_cnt < STARVE_LIMIT or !i_req) -> ACC_D
//    - else i_req -> ACC_I
//    - else dump_req -> DUMP
//  - Starvation counter (starve_cnt, 4 bits):
//    - Increments when D wins while i_req=1.
//    - Clears when I wins or when i_req=0.
//    - Saturates at STARVE_LIMIT.
//  - On entry to ACC_x, request fields are latched and x_gnt=1 for that cycle.
//  - Memory drive during ACC_x, from latched fields:
//    - Lane 0 always holds the byte at mem_addr.
//    - mem_byte_en: byte=0001, half=0011, word=1111; I always 1111.
//    - mem_wdata = d_wdata with unused lanes forced to 0.
//    - mem_wr = ACC_D & wr_latched & !rst; a reset cycle never commits a write.
//  - Outside ACC_x/DUMP: mem_byte_en=0, mem_wr=0, mem_wdata=0. mem_addr holds its last value (0 after reset).
//  - Illegal size (11): ACC_D still entered and d_gnt pulses, but mem_byte_en=0 and mem_wr=0.
//    Response is d_err=1, d_rdata=0.
//  - Response: at the posedge ending ACC_x, mem_rdata is captured and formatted.
//    x_rvalid=1 in the following cycle (latency: gnt cycle +1).
//    - Byte load: bits[31:8] = signed ? {24{rdata[7]}} : 0.
//    - Half load: bits[31:16] = signed ? {16{rdata[15]}} : 0.
//    - Word load: rdata unchanged.
//    - Store: d_rdata=0, d_rvalid=1 as ack.
//  - d_rdata/i_rdata hold their value until the next response.
//  - DUMP: mem_dump=1 for exactly 1 cycle; dump_done=1 the next cycle.
//  - Reset (any state): next cycle state=IDLE, starve_cnt=0.
//    All outputs 0 (gnt, rvalid, err, rdata, mem_*, dump_done).
//    An in-flight access is dropped with no rvalid.
//  - Simultaneous i_req, d_req and dump_req: dump waits until both request lines are low in IDLE.
// TESTING
//  - Single load: d_req, size=00, signed=1, addr=0x103, mem byte 0x80 -> d_gnt cycle N; mem_byte_en=0001, addr=0x103; cycle N+1 d_rvalid, d_rdata=0xFFFFFF80.
//  - Store/readback: store half 0xBEEF at 0x201 -> mem_wr=1 one cycle, byte_en=0011; word load 0x200 with byte0=0x11 -> 0x??BEEF11 per memory contents, byte 0x203 untouched.
//  - Starvation: i_req and d_req held high, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D,D,D,D,I...
//  - Illegal size: d_size=11, d_wr=1 -> d_gnt, mem_wr stays 0, next cycle d_rvalid=1, d_err=1.
//  - Reset mid-access: rst=1 during ACC_D store -> mem_wr=0 that cycle; no d_rvalid; all outputs 0 next cycle.
//  - Dump: dump_req with i_req pending -> I served first, then mem_dump 1 cycle, then dump_done 1 cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one byte-addressable memory between fetch (I) and load/store (D) with D priority,
// a starvation guard for I, and an idle-time dump sequencer. Single-cycle accesses, response next cycle.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [1:0]  d_size,
  input  logic        d_signed,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  input  logic        dump_req,
  output logic        dump_done,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byte_en,
  output logic        mem_wr,
  output logic        mem_dump,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ACC_I, ACC_D, DUMP} state_t;

  state_t      state_q;
  logic [3:0]  starve_q, starve_d;
  logic        wr_q, signed_q;
  logic [1:0]  size_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic [3:0]  mem_be_q;
  logic        mem_wr_q, mem_dump_q;
  logic        i_gnt_q, d_gnt_q, i_rvalid_q, d_rvalid_q, d_err_q, dump_done_q;
  logic [31:0] i_rdata_q, d_rdata_q;

  logic        d_win;
  logic [3:0]  d_be_d;
  logic [31:0] d_wdata_d, d_load_d;

  assign d_win = d_req && ((starve_q < LIMIT) || !i_req);

  always_comb begin
    starve_d = starve_q;
    if (!i_req)
      starve_d = '0;
    else if (state_q == IDLE) begin
      if (d_win)
        starve_d = (starve_q < LIMIT) ? starve_q + 4'd1 : starve_q;
      else
        starve_d = '0;
    end
  end

  // Lane 0 carries the addressed byte, so masking the unused lanes is all the alignment needed.
  always_comb begin
    d_be_d    = 4'b0000;
    d_wdata_d = 32'h0;
    case (d_size)
      2'b00: begin d_be_d = 4'b0001; d_wdata_d = {24'h0, d_wdata[7:0]};  end
      2'b01: begin d_be_d = 4'b0011; d_wdata_d = {16'h0, d_wdata[15:0]}; end
      2'b10: begin d_be_d = 4'b1111; d_wdata_d = d_wdata;                end
      default: ;
    endcase
  end

  always_comb begin
    d_load_d = 32'h0;
    if (!wr_q) begin
      case (size_q)
        2'b00: d_load_d = {(signed_q ? {24{mem_rdata[7]}}  : 24'h0), mem_rdata[7:0]};
        2'b01: d_load_d = {(signed_q ? {16{mem_rdata[15]}} : 16'h0), mem_rdata[15:0]};
        2'b10: d_load_d = mem_rdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      wr_q        <= 1'b0;
      signed_q    <= 1'b0;
      size_q      <= 2'b00;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      mem_wr_q    <= 1'b0;
      mem_dump_q  <= 1'b0;
      i_gnt_q     <= 1'b0;
      d_gnt_q     <= 1'b0;
      i_rvalid_q  <= 1'b0;
      d_rvalid_q  <= 1'b0;
      d_err_q     <= 1'b0;
      dump_done_q <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      starve_q    <= starve_d;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      mem_wr_q    <= 1'b0;
      mem_dump_q  <= 1'b0;
      i_gnt_q     <= 1'b0;
      d_gnt_q     <= 1'b0;
      i_rvalid_q  <= 1'b0;
      d_rvalid_q  <= 1'b0;
      d_err_q     <= 1'b0;
      dump_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (d_win) begin
            state_q     <= ACC_D;
            d_gnt_q     <= 1'b1;
            wr_q        <= d_wr;
            size_q      <= d_size;
            signed_q    <= d_signed;
            mem_addr_q  <= d_addr;
            mem_be_q    <= d_be_d;
            mem_wdata_q <= d_wdata_d;
            mem_wr_q    <= d_wr && (d_size != 2'b11);
          end else if (i_req) begin
            state_q    <= ACC_I;
            i_gnt_q    <= 1'b1;
            mem_addr_q <= i_addr;
            mem_be_q   <= 4'b1111;
          end else if (dump_req) begin
            state_q    <= DUMP;
            mem_dump_q <= 1'b1;
          end
        end
        ACC_I: begin
          state_q    <= IDLE;
          i_rvalid_q <= 1'b1;
          i_rdata_q  <= mem_rdata;
        end
        ACC_D: begin
          state_q    <= IDLE;
          d_rvalid_q <= 1'b1;
          d_err_q    <= (size_q == 2'b11);
          d_rdata_q  <= d_load_d;
        end
        DUMP: begin
          state_q     <= IDLE;
          dump_done_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign i_gnt       = i_gnt_q;
  assign i_rvalid    = i_rvalid_q;
  assign i_rdata     = i_rdata_q;
  assign d_gnt       = d_gnt_q;
  assign d_rvalid    = d_rvalid_q;
  assign d_rdata     = d_rdata_q;
  assign d_err       = d_err_q;
  assign dump_done   = dump_done_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_byte_en = mem_be_q;
  // Gate with reset so a store caught by reset never reaches the memory.
  assign mem_wr      = mem_wr_q & ~rst;
  assign mem_dump    = mem_dump_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a byte-wide memory model driven from the stimulus thread.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt, i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req, d_wr, d_signed;
  logic [1:0]  d_size;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic        dump_req, dump_done;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_byte_en;
  logic        mem_wr, mem_dump;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:1023];
  logic [9:0] ma;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_signed(d_signed), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .dump_req(dump_req), .dump_done(dump_done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_byte_en(mem_byte_en), .mem_wr(mem_wr),
    .mem_dump(mem_dump), .mem_rdata(mem_rdata)
  );

  assign ma        = mem_addr[9:0];
  assign mem_rdata = {mem[ma + 10'd3], mem[ma + 10'd2], mem[ma + 10'd1], mem[ma]};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; memory write uses the values presented at the edge, then outputs are sampled at +1.
  task automatic step();
    logic        w;
    logic [9:0]  a;
    logic [3:0]  be;
    logic [31:0] wd;
    @(negedge clk);
    w = mem_wr; a = mem_addr[9:0]; be = mem_byte_en; wd = mem_wdata;
    @(posedge clk);
    #1;
    if (w)
      for (int k = 0; k < 4; k++)
        if (be[k]) mem[a + 10'(k)] = wd[8*k +: 8];
  endtask

  function automatic logic any_out();
    return |{i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_err, dump_done,
             mem_addr, mem_wdata, mem_byte_en, mem_wr, mem_dump};
  endfunction

  initial begin
    logic exp_i [10];
    logic got_i [10];
    int   n;
    exp_i = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    for (int k = 0; k < 1024; k++) mem[k] = 8'h00;
    mem[10'h103] = 8'h80;
    mem[10'h200] = 8'h11;
    mem[10'h203] = 8'h77;

    rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_wr = 1'b0; d_size = 2'b00;
    d_signed = 1'b0; d_addr = '0; d_wdata = '0; dump_req = 1'b0;
    step(); step();
    chk("reset_outputs", {31'h0, any_out()}, 32'h0);
    rst = 1'b0;
    step();

    // Signed byte load from an odd address
    d_req = 1'b1; d_wr = 1'b0; d_size = 2'b00; d_signed = 1'b1; d_addr = 32'h103;
    step();
    chk("ld_b_gnt", {31'h0, d_gnt}, 32'h1);
    chk("ld_b_be", {28'h0, mem_byte_en}, 32'h1);
    chk("ld_b_addr", mem_addr, 32'h103);
    d_req = 1'b0;
    step();
    chk("ld_b_rvalid", {31'h0, d_rvalid}, 32'h1);
    chk("ld_b_rdata", d_rdata, 32'hFFFFFF80);
    chk("ld_b_idle_be", {28'h0, mem_byte_en}, 32'h0);
    chk("ld_b_addr_hold", mem_addr, 32'h103);
    step();
    chk("rdata_hold", d_rdata, 32'hFFFFFF80);

    // Half store at 0x201, upper lanes of write data must be masked
    d_req = 1'b1; d_wr = 1'b1; d_size = 2'b01; d_signed = 1'b0; d_addr = 32'h201; d_wdata = 32'h1234BEEF;
    step();
    chk("st_h_gnt", {31'h0, d_gnt}, 32'h1);
    chk("st_h_wr", {31'h0, mem_wr}, 32'h1);
    chk("st_h_be", {28'h0, mem_byte_en}, 32'h3);
    chk("st_h_wdata", mem_wdata, 32'h0000BEEF);
    d_req = 1'b0;
    step();
    chk("st_h_ack", {31'h0, d_rvalid}, 32'h1);
    chk("st_h_rdata", d_rdata, 32'h0);
    chk("st_h_wr_off", {31'h0, mem_wr}, 32'h0);
    step();

    d_req = 1'b1; d_wr = 1'b0; d_size = 2'b10; d_addr = 32'h200;
    step();
    d_req = 1'b0;
    step();
    chk("ld_w_rdata", d_rdata, 32'h77BEEF11);

    d_req = 1'b1; d_size = 2'b01; d_signed = 1'b1; d_addr = 32'h201;
    step();
    d_req = 1'b0;
    step();
    chk("ld_h_signed", d_rdata, 32'hFFFFBEEF);

    d_req = 1'b1; d_size = 2'b01; d_signed = 1'b0; d_addr = 32'h201;
    step();
    d_req = 1'b0;
    step();
    chk("ld_h_unsigned", d_rdata, 32'h0000BEEF);

    // Starvation guard with both requesters held high
    i_req = 1'b1; i_addr = 32'h0; d_req = 1'b1; d_wr = 1'b0; d_size = 2'b10; d_addr = 32'h0;
    n = 0;
    for (int c = 0; c < 60 && n < 10; c++) begin
      step();
      if (d_gnt || i_gnt) begin
        got_i[n] = i_gnt;
        n++;
      end
    end
    chk("starve_budget", n, 10);
    for (int k = 0; k < n; k++) chk($sformatf("starve_grant%0d", k), {31'h0, got_i[k]}, {31'h0, exp_i[k]});
    i_req = 1'b0; d_req = 1'b0;
    step(); step(); step();

    // Illegal size store
    d_req = 1'b1; d_wr = 1'b1; d_size = 2'b11; d_addr = 32'h300; d_wdata = 32'hFFFFFFFF;
    step();
    chk("ill_gnt", {31'h0, d_gnt}, 32'h1);
    chk("ill_wr", {31'h0, mem_wr}, 32'h0);
    chk("ill_be", {28'h0, mem_byte_en}, 32'h0);
    d_req = 1'b0;
    step();
    chk("ill_rvalid", {31'h0, d_rvalid}, 32'h1);
    chk("ill_err", {31'h0, d_err}, 32'h1);
    chk("ill_rdata", d_rdata, 32'h0);
    chk("ill_mem", {24'h0, mem[10'h300]}, 32'h0);
    step();

    // Reset lands during a store access
    d_req = 1'b1; d_wr = 1'b1; d_size = 2'b10; d_addr = 32'h304; d_wdata = 32'hCAFEF00D;
    step();
    chk("rst_st_wr_pre", {31'h0, mem_wr}, 32'h1);
    rst = 1'b1;
    #1;
    chk("rst_st_wr_gated", {31'h0, mem_wr}, 32'h0);
    d_req = 1'b0;
    step();
    chk("rst_st_no_rvalid", {31'h0, d_rvalid}, 32'h0);
    chk("rst_st_outputs", {31'h0, any_out()}, 32'h0);
    chk("rst_st_mem", {24'h0, mem[10'h304]}, 32'h0);
    rst = 1'b0;
    step();

    // Dump waits behind a pending fetch
    dump_req = 1'b1; i_req = 1'b1; i_addr = 32'h200;
    step();
    chk("dump_i_gnt", {31'h0, i_gnt}, 32'h1);
    chk("dump_i_be", {28'h0, mem_byte_en}, 32'hF);
    chk("dump_not_yet", {31'h0, mem_dump}, 32'h0);
    i_req = 1'b0;
    step();
    chk("dump_i_rvalid", {31'h0, i_rvalid}, 32'h1);
    chk("dump_i_rdata", i_rdata, 32'h77BEEF11);
    step();
    chk("dump_strobe", {31'h0, mem_dump}, 32'h1);
    chk("dump_done_early", {31'h0, dump_done}, 32'h0);
    dump_req = 1'b0;
    step();
    chk("dump_done", {31'h0, dump_done}, 32'h1);
    chk("dump_strobe_off", {31'h0, mem_dump}, 32'h0);
    step();
    chk("dump_done_off", {31'h0, dump_done}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
